// File: rtl/secuenciador_preparacion_if.sv
// Handshake and actuator bundle between the machine controller and the dispense sequencer.
// The controller drives the order request and configuration; the sequencer drives actuators and status.
`timescale 1ns/1ps
interface secuenciador_preparacion_if;
    logic       iniciar;
    logic       abortar;
    logic       concentracion;
    logic       leche;
    logic       espuma;
    logic [2:0] nivel_azucar;
    logic       molino;
    logic       bomba_agua;
    logic       valvula_leche;
    logic       espumador;
    logic       dosificador_azucar;
    logic       ocupado;
    logic       listo;
    logic [2:0] estado;

    modport master (
        output iniciar, abortar, concentracion, leche, espuma, nivel_azucar,
        input  molino, bomba_agua, valvula_leche, espumador, dosificador_azucar,
        input  ocupado, listo, estado
    );

    modport slave (
        input  iniciar, abortar, concentracion, leche, espuma, nivel_azucar,
        output molino, bomba_agua, valvula_leche, espumador, dosificador_azucar,
        output ocupado, listo, estado
    );
endinterface

// File: rtl/secuenciador_preparacion.sv
// Timed dispense sequencer: latches the drink configuration on start, then runs grinder,
// water, milk, foam and sugar phases of fixed length, skipping phases the order does not request.
//
//   state  | meaning
//   IDLE   | waiting for a paid order (iniciar)
//   MOLIDO | grinder on
//   AGUA   | water pump on (single or double shot length)
//   LECHE  | milk valve on
//   ESPUMA | frother on
//   AZUCAR | sugar doser on, length scales with the clamped level
//   FIN    | one-cycle done pulse
`timescale 1ns/1ps
module secuenciador_preparacion #(
    parameter int T_MOLIDO        = 4,
    parameter int T_AGUA_SIMPLE   = 6,
    parameter int T_AGUA_DOBLE    = 10,
    parameter int T_LECHE         = 5,
    parameter int T_ESPUMA        = 3,
    parameter int T_AZUCAR_UNIDAD = 2,
    parameter int CW              = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    secuenciador_preparacion_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        MOLIDO = 3'd1,
        AGUA   = 3'd2,
        LECHE  = 3'd3,
        ESPUMA = 3'd4,
        AZUCAR = 3'd5,
        FIN    = 3'd6
    } estado_t;

    localparam logic [CW-1:0] L_MOLIDO  = CW'(T_MOLIDO - 1);
    localparam logic [CW-1:0] L_SIMPLE  = CW'(T_AGUA_SIMPLE - 1);
    localparam logic [CW-1:0] L_DOBLE   = CW'(T_AGUA_DOBLE - 1);
    localparam logic [CW-1:0] L_LECHE   = CW'(T_LECHE - 1);
    localparam logic [CW-1:0] L_ESPUMA  = CW'(T_ESPUMA - 1);
    localparam logic [CW-1:0] L_UNIDAD  = CW'(T_AZUCAR_UNIDAD);

    estado_t       r_estado;
    estado_t       w_estado_sig;
    estado_t       w_tras_agua;
    estado_t       w_tras_leche;
    estado_t       w_tras_espuma;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_sig;
    logic [CW-1:0] w_azucar_len;
    logic          r_conc;
    logic          r_leche;
    logic          r_espuma;
    logic [2:0]    r_azucar;
    logic [2:0]    w_nivel_sat;
    logic          w_arranque;
    logic          w_avanza;

    assign w_nivel_sat  = (bus.nivel_azucar > 3'd5) ? 3'd5 : bus.nivel_azucar;
    assign w_arranque   = (r_estado == IDLE) && bus.iniciar && !bus.abortar;
    assign w_azucar_len = CW'(r_azucar) * L_UNIDAD;

    // Skip chain: each phase falls through to the next one the latched order requests.
    assign w_tras_espuma = (r_azucar != 3'd0) ? AZUCAR : FIN;
    assign w_tras_leche  = r_espuma ? ESPUMA : w_tras_espuma;
    assign w_tras_agua   = r_leche  ? LECHE  : w_tras_leche;

    always_comb begin
        w_estado_sig = r_estado;
        w_avanza     = 1'b0;
        case (r_estado)
            IDLE: begin
                if (w_arranque) begin
                    w_estado_sig = MOLIDO;
                    w_avanza     = 1'b1;
                end
            end
            MOLIDO: begin
                if (r_cnt == '0) begin
                    w_estado_sig = AGUA;
                    w_avanza     = 1'b1;
                end
            end
            AGUA: begin
                if (r_cnt == '0) begin
                    w_estado_sig = w_tras_agua;
                    w_avanza     = 1'b1;
                end
            end
            LECHE: begin
                if (r_cnt == '0) begin
                    w_estado_sig = w_tras_leche;
                    w_avanza     = 1'b1;
                end
            end
            ESPUMA: begin
                if (r_cnt == '0) begin
                    w_estado_sig = w_tras_espuma;
                    w_avanza     = 1'b1;
                end
            end
            AZUCAR: begin
                if (r_cnt == '0) begin
                    w_estado_sig = FIN;
                    w_avanza     = 1'b1;
                end
            end
            FIN: begin
                w_estado_sig = IDLE;
                w_avanza     = 1'b1;
            end
            default: begin
                w_estado_sig = IDLE;
                w_avanza     = 1'b1;
            end
        endcase
        if (bus.abortar && (r_estado != IDLE)) begin
            w_estado_sig = IDLE;
            w_avanza     = 1'b1;
        end
    end

    // The counter is loaded with (duration-1) of whatever phase is being entered.
    always_comb begin
        w_cnt_sig = r_cnt;
        if (w_avanza) begin
            case (w_estado_sig)
                MOLIDO:  w_cnt_sig = L_MOLIDO;
                AGUA:    w_cnt_sig = r_conc ? L_DOBLE : L_SIMPLE;
                LECHE:   w_cnt_sig = L_LECHE;
                ESPUMA:  w_cnt_sig = L_ESPUMA;
                AZUCAR:  w_cnt_sig = w_azucar_len - CW'(1);
                default: w_cnt_sig = '0;
            endcase
        end else if (r_estado != IDLE) begin
            w_cnt_sig = r_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_estado <= IDLE;
            r_cnt    <= '0;
            r_conc   <= 1'b0;
            r_leche  <= 1'b0;
            r_espuma <= 1'b0;
            r_azucar <= 3'd0;
        end else begin
            r_estado <= w_estado_sig;
            r_cnt    <= w_cnt_sig;
            if (w_arranque) begin
                r_conc   <= bus.concentracion;
                r_leche  <= bus.leche;
                r_espuma <= bus.espuma;
                r_azucar <= w_nivel_sat;
            end
        end
    end

    assign bus.molino             = (r_estado == MOLIDO);
    assign bus.bomba_agua         = (r_estado == AGUA);
    assign bus.valvula_leche      = (r_estado == LECHE);
    assign bus.espumador          = (r_estado == ESPUMA);
    assign bus.dosificador_azucar = (r_estado == AZUCAR);
    assign bus.ocupado            = (r_estado != IDLE);
    assign bus.listo              = (r_estado == FIN);
    assign bus.estado             = r_estado;

endmodule

// File: tb/tb_secuenciador_preparacion.sv
// Directed bench for the dispense sequencer: expected per-cycle output vectors are queued when
// an order is driven and compared one per clock against the registered outputs.
`timescale 1ns/1ps
module tb_secuenciador_preparacion;

    localparam int T_M   = 4;
    localparam int T_AS  = 6;
    localparam int T_AD  = 10;
    localparam int T_L   = 5;
    localparam int T_E   = 3;
    localparam int T_AZU = 2;

    localparam logic [2:0] S_IDLE = 3'd0, S_MOL = 3'd1, S_AGUA = 3'd2, S_LECHE = 3'd3,
                           S_ESP = 3'd4, S_AZU = 3'd5, S_FIN = 3'd6;

    logic clk;
    logic reset;
    secuenciador_preparacion_if bus ();

    secuenciador_preparacion #(
        .T_MOLIDO(T_M), .T_AGUA_SIMPLE(T_AS), .T_AGUA_DOBLE(T_AD),
        .T_LECHE(T_L), .T_ESPUMA(T_E), .T_AZUCAR_UNIDAD(T_AZU), .CW(5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [9:0] q_exp[$];
    int         vectors = 0;
    int         miscompares = 0;
    string      tag = "init";

    // Packed as {estado, molino, bomba, valvula, espumador, dosificador, ocupado, listo}.
    function automatic logic [9:0] vec(input logic [2:0] s);
        return {s, s == S_MOL, s == S_AGUA, s == S_LECHE, s == S_ESP, s == S_AZU,
                s != S_IDLE, s == S_FIN};
    endfunction

    task automatic push_n(input logic [2:0] s, input int n);
        for (int i = 0; i < n; i++) q_exp.push_back(vec(s));
    endtask

    task automatic push_orden(input logic conc, input logic le, input logic es, input int niv);
        int nv;
        nv = (niv > 5) ? 5 : niv;
        push_n(S_MOL, T_M);
        push_n(S_AGUA, conc ? T_AD : T_AS);
        if (le) push_n(S_LECHE, T_L);
        if (es) push_n(S_ESP, T_E);
        if (nv != 0) push_n(S_AZU, nv * T_AZU);
        push_n(S_FIN, 1);
        push_n(S_IDLE, 1);
    endtask

    task automatic ciclo();
        logic [9:0] obs;
        logic [9:0] exp_v;
        @(posedge clk);
        #1;
        obs = {bus.estado, bus.molino, bus.bomba_agua, bus.valvula_leche, bus.espumador,
               bus.dosificador_azucar, bus.ocupado, bus.listo};
        vectors++;
        if (q_exp.size() == 0) begin
            miscompares++;
            $error("FAIL %s: no expected vector queued, observed %b", tag, obs);
        end else begin
            exp_v = q_exp.pop_front();
            assert (obs === exp_v) else begin
                miscompares++;
                $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) ciclo();
    endtask

    task automatic vaciar();
        int guard;
        guard = 0;
        while (q_exp.size() > 0 && guard < 200) begin
            ciclo();
            guard++;
        end
    endtask

    task automatic iniciar_orden(input logic conc, input logic le, input logic es,
                                 input logic [2:0] niv);
        bus.iniciar       = 1'b1;
        bus.concentracion = conc;
        bus.leche         = le;
        bus.espuma        = es;
        bus.nivel_azucar  = niv;
    endtask

    task automatic limpiar();
        bus.iniciar       = 1'b0;
        bus.concentracion = 1'b0;
        bus.leche         = 1'b0;
        bus.espuma        = 1'b0;
        bus.nivel_azucar  = 3'd0;
    endtask

    initial begin
        reset       = 1'b0;
        bus.abortar = 1'b0;
        limpiar();

        tag = "reset";
        push_n(S_IDLE, 2);
        run(2);
        reset = 1'b1;
        push_n(S_IDLE, 1);
        run(1);

        tag = "espresso";
        iniciar_orden(1'b0, 1'b0, 1'b0, 3'd0);
        push_orden(1'b0, 1'b0, 1'b0, 0);
        ciclo();
        limpiar();
        vaciar();

        tag = "cappuccino";
        iniciar_orden(1'b1, 1'b1, 1'b1, 3'd3);
        push_orden(1'b1, 1'b1, 1'b1, 3);
        ciclo();
        limpiar();
        vaciar();

        tag = "abort_agua";
        iniciar_orden(1'b0, 1'b0, 1'b0, 3'd0);
        push_n(S_MOL, T_M);
        push_n(S_AGUA, 3);
        push_n(S_IDLE, 1);
        ciclo();
        limpiar();
        run(T_M - 1 + 3);
        bus.abortar = 1'b1;
        ciclo();
        bus.abortar = 1'b0;
        tag = "restart_after_abort";
        iniciar_orden(1'b0, 1'b0, 1'b0, 3'd0);
        push_orden(1'b0, 1'b0, 1'b0, 0);
        ciclo();
        limpiar();
        vaciar();

        tag = "abort_beats_start";
        bus.abortar = 1'b1;
        iniciar_orden(1'b1, 1'b1, 1'b1, 3'd5);
        push_n(S_IDLE, 2);
        run(2);
        bus.abortar = 1'b0;
        limpiar();

        tag = "ignore_midrun";
        iniciar_orden(1'b0, 1'b0, 1'b0, 3'd0);
        push_orden(1'b0, 1'b0, 1'b0, 0);
        push_n(S_IDLE, 2);
        ciclo();
        bus.iniciar = 1'b1;
        bus.leche   = 1'b1;
        bus.espuma  = 1'b1;
        bus.nivel_azucar = 3'd4;
        run(T_M - 1);
        limpiar();
        vaciar();

        tag = "reset_in_leche";
        iniciar_orden(1'b0, 1'b1, 1'b0, 3'd0);
        push_n(S_MOL, T_M);
        push_n(S_AGUA, T_AS);
        push_n(S_LECHE, 2);
        push_n(S_IDLE, 3);
        ciclo();
        limpiar();
        run(T_M + T_AS + 2 - 1);
        reset = 1'b0;
        ciclo();
        reset = 1'b1;
        run(2);

        tag = "sugar_clamp";
        iniciar_orden(1'b0, 1'b0, 1'b0, 3'd7);
        push_orden(1'b0, 1'b0, 1'b0, 7);
        ciclo();
        limpiar();
        vaciar();

        tag = "abort_in_fin";
        iniciar_orden(1'b0, 1'b0, 1'b0, 3'd0);
        push_n(S_MOL, T_M);
        push_n(S_AGUA, T_AS);
        push_n(S_FIN, 1);
        push_n(S_IDLE, 2);
        ciclo();
        limpiar();
        run(T_M + T_AS);
        bus.abortar = 1'b1;
        ciclo();
        bus.abortar = 1'b0;
        vaciar();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
